seven_seg_scan_pio: RTL
=======================

SEVEN_SEG_SCAN_PIO -- requirements
Module: seven_seg_scan_pio

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL provide parameter SCAN_DIV, default 1000, clocks per digit slot (>= 2).
REQ-003 SHALL provide parameter BLANK_CYC, default 8, clocks at the start of each slot with all digits off (< SCAN_DIV).
REQ-004 SHALL provide parameter BLINK_DIV, default 256, number of full scan frames per blink phase (>= 1).
REQ-005 clk  input  1  system clock; all logic is synchronous to the rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 address  input  2  register select.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 read_n  input  1  active-low read strobe.
REQ-011 writedata  input  32  write data.
REQ-012 readdata  output  32  registered read data.
REQ-013 seg  output  8  segments, active-high: seg[6:0] = g..a, seg[7] = dp.
REQ-014 digit_sel  output  DIGITS  one-hot digit enable, active-high.

Function
REQ-015 Registers: addr0 DATA[4*DIGITS-1:0], one hex nibble per digit, digit 0 in bits [3:0]; addr1 DP[DIGITS-1:0]; addr2 CTRL, bit0 = EN, bit1 = BLINK; addr3 BLANK[DIGITS-1:0], per-digit blank mask.
REQ-016 Write when chipselect && !write_n: the addressed register loads writedata (unused bits are dropped), and display logic uses the new value from the next clock.
REQ-017 Read when chipselect && !read_n: readdata returns the addressed register, zero-extended, one clock later (read latency 1); at all other times readdata holds its previous value.
REQ-018 Prescaler counts 0..SCAN_DIV-1; at the terminal count it wraps to 0 and the digit index advances, wrapping DIGITS-1 -> 0.
REQ-019 digit_sel = one-hot(index) when EN=1, prescaler >= BLANK_CYC, BLANK[index]=0 and the blink phase is on; otherwise all zeros.
REQ-020 seg[6:0] = hex decode of DATA nibble[index]: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; seg[7] = DP[index]; seg = 0 whenever digit_sel = 0.
REQ-021 seg and digit_sel SHALL be registered, one clock after the prescaler/index state that selects them, with no glitches.
REQ-022 Blink: a frame counter increments each time the index wraps to 0, and the blink phase toggles every BLINK_DIV frames; phase on = 1 after reset; with BLINK=0 the phase is forced on.
REQ-023 EN=0 holds prescaler, index, frame counter and phase at their reset values; a write of EN=0 coincident with a slot wrap takes priority.
REQ-024 When EN changes 0->1, scanning starts at index 0 with prescaler 0 on the next clock.
REQ-025 A register write coincident with a slot boundary is displayed in the new slot.

Reset
REQ-026 On reset_n low, immediately: DATA, DP, CTRL, BLANK, prescaler, index and frame counter = 0; blink phase = on; seg = 0; digit_sel = 0; readdata = 0.
REQ-027 Reset asserted mid-scan SHALL blank the outputs asynchronously, with no partial slot completion after release.

Configuration
REQ-028 Macro SEVEN_SEG_BLINK_EN defined: the blink logic of REQ-022 is compiled in.
REQ-029 Macro not defined: no frame counter or phase logic, phase permanently on, CTRL bit1 write ignored, reads 0.

Verification (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=2)
REQ-030 Reset, then write CTRL=1 and DATA=0x3210 -> digit_sel 0001 seg 3F, 0010 seg 06, 0100 seg 5B, 1000 seg 4F, each for 3 clocks after 1 blank clock, then repeats.
REQ-031 Write DP=0x5 and BLANK=0x2 -> digit 0 seg BF, digit 1 never selected, digit 2 seg DB.
REQ-032 Read addr0 after writing 0xFFFF_ABCD -> readdata = 0x0000_ABCD exactly one clock after the read strobe.
REQ-033 With macro defined, CTRL=3 -> digits on for 2 frames (32 clocks), all off for 2 frames, repeating; without macro, CTRL reads back 1 and the display is always on.
REQ-034 Write CTRL=0 mid-slot -> seg = 0 and digit_sel = 0 next clock; rewrite CTRL=1 -> digit 0 is selected after 1 blank clock.
REQ-035 Assert reset_n mid-slot -> seg, digit_sel and readdata = 0 before the next clock edge; all registers read 0 after release.

Source files
------------

// File: rtl/seven_seg_scan_pio.sv
// Memory-mapped multiplexed seven-segment scanner with per-digit DP/blank and a registered read port.
// Define SEVEN_SEG_BLINK_EN to compile in the frame-based blink logic controlled by CTRL bit1.
module seven_seg_scan_pio #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8,
  parameter int BLINK_DIV = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [PS_W-1:0]  PS_BLANK = PS_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h3F;
      4'h1:    hex_to_seg = 7'h06;
      4'h2:    hex_to_seg = 7'h5B;
      4'h3:    hex_to_seg = 7'h4F;
      4'h4:    hex_to_seg = 7'h66;
      4'h5:    hex_to_seg = 7'h6D;
      4'h6:    hex_to_seg = 7'h7D;
      4'h7:    hex_to_seg = 7'h07;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h6F;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h7C;
      4'hC:    hex_to_seg = 7'h39;
      4'hD:    hex_to_seg = 7'h5E;
      4'hE:    hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  logic [4*DIGITS-1:0] r_data;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_blank;
  logic                r_en;
  logic [PS_W-1:0]     r_presc;
  logic [IDX_W-1:0]    r_idx;

  logic                w_wr;
  logic                w_rd;
  logic                w_en_clr;
  logic                w_slot_wrap;
  logic                w_idx_wrap;
  logic                w_phase_on;
  logic                w_blink_bit;
  logic                w_show;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_onehot;
  logic [31:0]         w_rd_val;
  logic                w_unused_wdata;

  assign w_wr     = chipselect && !write_n;
  assign w_rd     = chipselect && !read_n;
  // A write that clears EN resets the scan state on the same edge, even at a slot wrap.
  assign w_en_clr = w_wr && (address == 2'd2) && !writedata[0];
  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_dp    <= '0;
      r_en    <= 1'b0;
      r_blank <= '0;
    end else if (w_wr) begin
      case (address)
        2'd0:    r_data  <= writedata[4*DIGITS-1:0];
        2'd1:    r_dp    <= writedata[DIGITS-1:0];
        2'd2:    r_en    <= writedata[0];
        default: r_blank <= writedata[DIGITS-1:0];
      endcase
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (address)
      2'd0:    w_rd_val[4*DIGITS-1:0] = r_data;
      2'd1:    w_rd_val[DIGITS-1:0]   = r_dp;
      2'd2:    w_rd_val[1:0]          = {w_blink_bit, r_en};
      default: w_rd_val[DIGITS-1:0]   = r_blank;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (w_rd) begin
      readdata <= w_rd_val;
    end
  end

  assign w_slot_wrap = (r_presc == PS_LAST);
  assign w_idx_wrap  = w_slot_wrap && (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (!r_en || w_en_clr) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_slot_wrap) begin
      r_presc <= '0;
      r_idx   <= w_idx_wrap ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  logic             r_blink;
  logic             r_phase;
  logic [FRM_W-1:0] r_frame;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink <= 1'b0;
    end else if (w_wr && (address == 2'd2)) begin
      r_blink <= writedata[1];
    end
  end

  // Frame counter and phase sit at their reset values whenever scanning or blinking is off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= '0;
      r_phase <= 1'b1;
    end else if (!r_en || w_en_clr || !r_blink) begin
      r_frame <= '0;
      r_phase <= 1'b1;
    end else if (w_idx_wrap) begin
      if (r_frame == FRM_LAST) begin
        r_frame <= '0;
        r_phase <= !r_phase;
      end else begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

  assign w_phase_on  = !r_blink || r_phase;
  assign w_blink_bit = r_blink;
`else
  logic [FRM_W-1:0] w_frm_unused;

  assign w_frm_unused = FRM_LAST;
  assign w_phase_on   = 1'b1;
  assign w_blink_bit  = 1'b0;
`endif

  assign w_nib  = r_data[4*r_idx +: 4];
  assign w_show = r_en && (r_presc >= PS_BLANK) && !r_blank[r_idx] && w_phase_on;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_onehot[i] = (r_idx == IDX_W'(i));
    end
  end

  // Outputs are registered from the current slot state so they change cleanly once per clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg       <= '0;
      digit_sel <= '0;
    end else if (w_show) begin
      seg       <= {r_dp[r_idx], hex_to_seg(w_nib)};
      digit_sel <= w_onehot;
    end else begin
      seg       <= '0;
      digit_sel <= '0;
    end
  end

endmodule
